// File: rtl/data_mem_controller_pkg.sv
// rtl/data_mem_controller_pkg.sv - shared encodings and decode helpers for the data memory controller
// Holds the load/store funct3 encodings, control-word enable bit positions,
// FSM state encodings, the access size type and small decode functions.
package data_mem_controller_pkg;

    // Enable bit positions inside the load/store control words
    localparam int LD_EN_BIT = 3;
    localparam int ST_EN_BIT = 2;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings (low two bits)
    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_DONE   = 2'b10;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_e;

    // Loads and stores share the low two funct3 bits for width, so one
    // decoder serves both. Anything that is not byte or half is a word.
    function automatic mem_size_e decode_size(input logic [1:0] f3_lo);
        case (f3_lo)
            F3_SB:   return SIZE_BYTE;
            F3_SH:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_unsigned_load(input logic [2:0] f3);
        return (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_HALF: return offset[0];
            SIZE_WORD: return |offset;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane packing for stores and lane select/extension for loads
// Ports:
//   size        : access width (byte/half/word)
//   is_unsigned : zero-extend loads instead of sign-extend
//   offset      : byte address bits [1:0]
//   store_data  : raw store source register
//   load_word   : word returned by memory
//   wdata       : store data replicated across lanes
//   byte_en     : active byte lanes for the access
//   load_data   : selected and extended load result
module mem_lane_align
    import data_mem_controller_pkg::*;
(
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data
);

    // Lane of interest moved down to bit 0; only the low halfword is ever used
    logic [15:0] lane;
    assign lane = 16'(load_word >> {offset, 3'b000});

    always_comb begin
        wdata     = store_data;
        byte_en   = 4'b1111;
        load_data = load_word;
        case (size)
            SIZE_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                byte_en   = 4'b0001 << offset;
                load_data = is_unsigned ? {24'h000000, lane[7:0]}
                                        : {{24{lane[7]}}, lane[7:0]};
            end
            SIZE_HALF: begin
                wdata     = {2{store_data[15:0]}};
                byte_en   = 4'b0011 << offset;
                load_data = is_unsigned ? {16'h0000, lane}
                                        : {{16{lane[15]}}, lane};
            end
            default: begin
                wdata     = store_data;
                byte_en   = 4'b1111;
                load_data = load_word;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - MEM-stage data memory controller with stall handshake
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   MEM_ALU_OUT         : byte address from EX/MEM
//   MEM_REG_DATA2       : store source data
//   MEM_DATA_MEM_READ   : [3] load enable, [2:0] funct3
//   MEM_DATA_MEM_WRITE  : [2] store enable, [1:0] funct3 low
//   DMEM_READ/WRITE     : registered request strobes
//   DMEM_ADDR           : word-aligned request address
//   DMEM_WDATA          : lane-replicated store data
//   DMEM_BYTE_EN        : active byte lanes
//   DMEM_RDATA          : read word from memory
//   DMEM_ACK            : single-cycle completion
//   STALL               : freezes PC and pipeline registers
//   LOAD_DATA           : load result, valid in DONE only
//   MISALIGNED          : single-cycle fault pulse
module data_mem_controller
    import data_mem_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] MEM_ALU_OUT,
    input  logic [31:0] MEM_REG_DATA2,
    input  logic [3:0]  MEM_DATA_MEM_READ,
    input  logic [2:0]  MEM_DATA_MEM_WRITE,
    output logic        DMEM_READ,
    output logic        DMEM_WRITE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    output logic [3:0]  DMEM_BYTE_EN,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        STALL,
    output logic [31:0] LOAD_DATA,
    output logic        MISALIGNED
);

    logic [1:0]  state;
    logic        rd_req;
    logic        wr_req;
    logic        req_any;
    logic        req_misaligned;
    mem_size_e   req_size;
    logic        req_unsigned;

    // Width/signedness of the outstanding load, held for the unpack in ACCESS
    mem_size_e   lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_offset;
    logic [31:0] load_q;

    mem_size_e   align_size;
    logic        align_unsigned;
    logic [1:0]  align_offset;
    logic [31:0] align_wdata;
    logic [3:0]  align_byte_en;
    logic [31:0] align_load;

    // A load wins over a simultaneous store
    assign rd_req  = MEM_DATA_MEM_READ[LD_EN_BIT];
    assign wr_req  = MEM_DATA_MEM_WRITE[ST_EN_BIT] & ~rd_req;
    assign req_any = rd_req | wr_req;

    assign req_size       = rd_req ? decode_size(MEM_DATA_MEM_READ[1:0])
                                   : decode_size(MEM_DATA_MEM_WRITE[1:0]);
    assign req_unsigned   = rd_req & is_unsigned_load(MEM_DATA_MEM_READ[2:0]);
    assign req_misaligned = is_misaligned(req_size, MEM_ALU_OUT[1:0]);

    // One aligner serves both directions: in IDLE it packs the incoming
    // store, in ACCESS it unpacks the returned word for the latched load.
    assign align_size     = (state == ST_ACCESS) ? lat_size     : req_size;
    assign align_unsigned = (state == ST_ACCESS) ? lat_unsigned : req_unsigned;
    assign align_offset   = (state == ST_ACCESS) ? lat_offset   : MEM_ALU_OUT[1:0];

    mem_lane_align u_lane_align (
        .size        (align_size),
        .is_unsigned (align_unsigned),
        .offset      (align_offset),
        .store_data  (MEM_REG_DATA2),
        .load_word   (DMEM_RDATA),
        .wdata       (align_wdata),
        .byte_en     (align_byte_en),
        .load_data   (align_load)
    );

    // Stall must rise in the same cycle the access appears so the pipeline
    // holds the instruction in MEM until DONE.
    assign STALL = (state == ST_ACCESS) |
                   ((state == ST_IDLE) & req_any & ~req_misaligned);

    assign MISALIGNED = ~RESET & (state == ST_IDLE) & req_any & req_misaligned;

    assign LOAD_DATA = (state == ST_DONE) ? load_q : 32'h0000_0000;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            DMEM_READ    <= 1'b0;
            DMEM_WRITE   <= 1'b0;
            DMEM_ADDR    <= 32'h0000_0000;
            DMEM_WDATA   <= 32'h0000_0000;
            DMEM_BYTE_EN <= 4'b0000;
            load_q       <= 32'h0000_0000;
            lat_size     <= SIZE_WORD;
            lat_unsigned <= 1'b0;
            lat_offset   <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any && !req_misaligned) begin
                        state        <= ST_ACCESS;
                        DMEM_READ    <= rd_req;
                        DMEM_WRITE   <= wr_req;
                        DMEM_ADDR    <= {MEM_ALU_OUT[31:2], 2'b00};
                        DMEM_WDATA   <= wr_req ? align_wdata : 32'h0000_0000;
                        DMEM_BYTE_EN <= align_byte_en;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_offset   <= MEM_ALU_OUT[1:0];
                    end
                end
                ST_ACCESS: begin
                    if (DMEM_ACK) begin
                        state      <= ST_DONE;
                        DMEM_READ  <= 1'b0;
                        DMEM_WRITE <= 1'b0;
                        // Stores report zero in DONE
                        load_q     <= DMEM_READ ? align_load : 32'h0000_0000;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - scoreboard bench for data_mem_controller
module tb_data_mem_controller;

    logic        CLK;
    logic        RESET;
    logic [31:0] MEM_ALU_OUT;
    logic [31:0] MEM_REG_DATA2;
    logic [3:0]  MEM_DATA_MEM_READ;
    logic [2:0]  MEM_DATA_MEM_WRITE;
    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_ACK;
    logic        STALL;
    logic [31:0] LOAD_DATA;
    logic        MISALIGNED;

    data_mem_controller dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .MEM_ALU_OUT        (MEM_ALU_OUT),
        .MEM_REG_DATA2      (MEM_REG_DATA2),
        .MEM_DATA_MEM_READ  (MEM_DATA_MEM_READ),
        .MEM_DATA_MEM_WRITE (MEM_DATA_MEM_WRITE),
        .DMEM_READ          (DMEM_READ),
        .DMEM_WRITE         (DMEM_WRITE),
        .DMEM_ADDR          (DMEM_ADDR),
        .DMEM_WDATA         (DMEM_WDATA),
        .DMEM_BYTE_EN       (DMEM_BYTE_EN),
        .DMEM_RDATA         (DMEM_RDATA),
        .DMEM_ACK           (DMEM_ACK),
        .STALL              (STALL),
        .LOAD_DATA          (LOAD_DATA),
        .MISALIGNED         (MISALIGNED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
        int          stall;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [7:0] b[4];
        int k;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        k = int'(lo);
        case (f3)
            3'b000:  return {{24{b[k][7]}}, b[k]};
            3'b100:  return {24'h0, b[k]};
            3'b001:  return {{16{b[k+1][7]}}, b[k+1], b[k]};
            3'b101:  return {16'h0, b[k+1], b[k]};
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [1:0] f3, input logic [1:0] lo, input logic [31:0] d,
                               output logic [3:0] be, output logic [31:0] wd);
        int k;
        k  = int'(lo);
        be = 4'b0000;
        case (f3)
            2'b00: begin
                be[k] = 1'b1;
                wd = {d[7:0], d[7:0], d[7:0], d[7:0]};
            end
            2'b01: begin
                be[k] = 1'b1;
                be[k+1] = 1'b1;
                wd = {d[15:0], d[15:0]};
            end
            default: begin
                be = 4'b1111;
                wd = d;
            end
        endcase
    endtask

    task automatic clear_inputs();
        MEM_ALU_OUT        = 32'h0;
        MEM_REG_DATA2      = 32'h0;
        MEM_DATA_MEM_READ  = 4'h0;
        MEM_DATA_MEM_WRITE = 3'h0;
    endtask

    // Drive one aligned access, play memory with ACK after ack_wait extra
    // ACCESS cycles, and check request fields and DONE result.
    task automatic do_access(input logic [3:0] rctl, input logic [2:0] wctl,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int ack_wait);
        exp_t e;
        logic [3:0]  be;
        logic [31:0] wd;
        bit seen;
        bit done;
        int acc;
        int stalls;
        e.rd    = rctl[3];
        e.wr    = wctl[2] & ~rctl[3];
        e.addr  = addr & 32'hFFFF_FFFC;
        e.load  = e.rd ? model_load(rctl[2:0], addr[1:0], rdata) : 32'h0;
        model_store(wctl[1:0], addr[1:0], sdata, be, wd);
        e.be    = be;
        e.wdata = wd;
        e.stall = 2 + ack_wait;
        sb.push_back(e);

        @(negedge CLK);
        MEM_ALU_OUT        = addr;
        MEM_REG_DATA2      = sdata;
        MEM_DATA_MEM_READ  = rctl;
        MEM_DATA_MEM_WRITE = wctl;
        DMEM_RDATA         = rdata;
        seen = 0; done = 0; acc = 0; stalls = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (STALL) stalls++;
            if (DMEM_READ || DMEM_WRITE) begin
                if (!seen) begin
                    seen = 1;
                    check_val("req_addr", DMEM_ADDR, sb[0].addr);
                    check_val("req_read", {31'h0, DMEM_READ}, {31'h0, sb[0].rd});
                    check_val("req_write", {31'h0, DMEM_WRITE}, {31'h0, sb[0].wr});
                    if (sb[0].wr) begin
                        check_val("req_byte_en", {28'h0, DMEM_BYTE_EN}, {28'h0, sb[0].be});
                        check_val("req_wdata", DMEM_WDATA, sb[0].wdata);
                    end
                end
                DMEM_ACK = (acc == ack_wait);
                acc++;
            end else if (seen) begin
                e = sb.pop_front();
                check_val("load_data", LOAD_DATA, e.load);
                check_val("stall_cycles", stalls, e.stall);
                DMEM_ACK = 1'b0;
                clear_inputs();
                done = 1;
            end
            @(negedge CLK);
        end
        if (!done) begin
            check_val("access_timeout", 32'h0, 32'h1);
            if (sb.size() > 0) void'(sb.pop_front());
            DMEM_ACK = 1'b0;
            clear_inputs();
        end
    endtask

    task automatic do_misaligned(input logic [3:0] rctl, input logic [2:0] wctl,
                                 input logic [31:0] addr);
        @(negedge CLK);
        MEM_ALU_OUT        = addr;
        MEM_DATA_MEM_READ  = rctl;
        MEM_DATA_MEM_WRITE = wctl;
        #1;
        check_val("mis_pulse", {31'h0, MISALIGNED}, 32'h1);
        check_val("mis_stall", {31'h0, STALL}, 32'h0);
        check_val("mis_load", LOAD_DATA, 32'h0);
        @(negedge CLK);
        clear_inputs();
        #1;
        check_val("mis_no_req", {30'h0, DMEM_READ, DMEM_WRITE}, 32'h0);
        check_val("mis_drop", {31'h0, MISALIGNED}, 32'h0);
    endtask

    initial begin
        RESET = 1'b1;
        DMEM_ACK = 1'b0;
        DMEM_RDATA = 32'h0;
        clear_inputs();
        repeat (2) @(negedge CLK);
        #1;
        check_val("rst_read", {31'h0, DMEM_READ}, 32'h0);
        check_val("rst_write", {31'h0, DMEM_WRITE}, 32'h0);
        check_val("rst_addr", DMEM_ADDR, 32'h0);
        check_val("rst_wdata", DMEM_WDATA, 32'h0);
        check_val("rst_byte_en", {28'h0, DMEM_BYTE_EN}, 32'h0);
        check_val("rst_misaligned", {31'h0, MISALIGNED}, 32'h0);
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        check_val("post_rst_stall", {31'h0, STALL}, 32'h0);
        check_val("post_rst_load", LOAD_DATA, 32'h0);

        // Stray ACK while idle must do nothing
        DMEM_ACK = 1'b1;
        @(negedge CLK);
        DMEM_ACK = 1'b0;
        #1;
        check_val("idle_ack_stall", {31'h0, STALL}, 32'h0);
        check_val("idle_ack_load", LOAD_DATA, 32'h0);

        do_access(4'b1010, 3'b000, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1);
        do_access(4'b1000, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF1234, 0);
        do_access(4'b1100, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF1234, 0);
        do_access(4'b1001, 3'b000, 32'h0000_0102, 32'h0, 32'h80FF1234, 2);
        do_access(4'b1101, 3'b000, 32'h0000_0100, 32'h0, 32'h80FF1234, 0);
        do_access(4'b1001, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_8234, 0);
        do_access(4'b0000, 3'b101, 32'h0000_0202, 32'h0000ABCD, 32'h0, 0);
        do_access(4'b0000, 3'b100, 32'h0000_0201, 32'h12345678, 32'h0, 1);
        do_access(4'b0000, 3'b110, 32'h0000_0204, 32'hCAFEF00D, 32'h0, 3);
        do_access(4'b1111, 3'b000, 32'h0000_0108, 32'h0, 32'h89ABCDEF, 0);
        do_access(4'b0000, 3'b111, 32'h0000_020C, 32'h01234567, 32'h0, 0);
        do_access(4'b1010, 3'b110, 32'h0000_0110, 32'h55555555, 32'hA5A5A5A5, 1);

        do_misaligned(4'b1010, 3'b000, 32'h0000_0101);
        do_misaligned(4'b1001, 3'b000, 32'h0000_0103);
        do_misaligned(4'b0000, 3'b110, 32'h0000_0202);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] f3;
            logic [1:0] lo;
            logic [2:0] ld_codes[5];
            ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            if ($urandom_range(0, 1) == 0) begin
                f3 = ld_codes[$urandom_range(0, 4)];
                lo = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
                     (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
                do_access({1'b1, f3}, 3'b000, 32'h400 + 32'(4 * i) + {30'h0, lo},
                          32'h0, $urandom, $urandom_range(0, 3));
            end else begin
                f3 = {1'b0, 2'($urandom_range(0, 2))};
                lo = (f3[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
                     (f3[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
                do_access(4'b0000, {1'b1, f3[1:0]}, 32'h500 + 32'(4 * i) + {30'h0, lo},
                          $urandom, 32'h0, $urandom_range(0, 3));
            end
        end

        // Reset while ACCESS is outstanding, then a late ACK
        @(negedge CLK);
        MEM_ALU_OUT       = 32'h0000_0300;
        MEM_DATA_MEM_READ = 4'b1010;
        DMEM_RDATA        = 32'h13579BDF;
        @(negedge CLK);
        #1;
        check_val("rst_acc_read", {31'h0, DMEM_READ}, 32'h1);
        RESET = 1'b1;
        clear_inputs();
        @(negedge CLK);
        #1;
        check_val("rst_acc_drop", {30'h0, DMEM_READ, DMEM_WRITE}, 32'h0);
        check_val("rst_acc_stall", {31'h0, STALL}, 32'h0);
        RESET    = 1'b0;
        DMEM_ACK = 1'b1;
        @(negedge CLK);
        #1;
        DMEM_ACK = 1'b0;
        check_val("late_ack_load", LOAD_DATA, 32'h0);
        check_val("late_ack_stall", {31'h0, STALL}, 32'h0);
        @(negedge CLK);
        #1;
        check_val("late_ack_load2", LOAD_DATA, 32'h0);
        check_val("late_ack_strobes", {30'h0, DMEM_READ, DMEM_WRITE}, 32'h0);

        do_access(4'b1010, 3'b000, 32'h0000_0304, 32'h0, 32'h2468ACE0, 0);

        check_val("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
